// File: rtl/out_buf_wr_sched.sv
// Write-side scheduler: spreads one pixel-group stream round-robin across NUM_SLICES buffers.
// Optional stall statistics enabled by defining OUT_BUF_WR_SCHED_STATS_EN.
module out_buf_wr_sched #(
  parameter int NUM_SLICES       = 4,
  parameter int DATA_WIDTH       = 168,
  parameter int PIX_PER_GROUP    = 4,
  parameter int MAX_SLICE_WIDTH  = 2560,
  parameter int MAX_SLICE_HEIGHT = 2560
) (
  input  logic                                clk_wr,
  input  logic                                rst_n,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  slice_width,
  input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] slice_height,
  input  logic                                frame_start,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_SLICES-1:0]               buf_almost_full,
  output logic [DATA_WIDTH-1:0]               wr_data,
  output logic [NUM_SLICES-1:0]               wr_valid,
  output logic [NUM_SLICES-1:0]               wr_sof,
  output logic [$clog2(NUM_SLICES)-1:0]       cur_slice,
  output logic                                frame_done,
  output logic [15:0]                         stall_cnt
);
  localparam int W_W = $clog2(MAX_SLICE_WIDTH);
  localparam int H_W = $clog2(MAX_SLICE_HEIGHT);
  localparam int S_W = $clog2(NUM_SLICES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [W_W:0]          gsum;
  logic [W_W-1:0]        gpl;
  logic [W_W-1:0]        grp_cnt;
  logic [H_W-1:0]        line_cnt;
  logic [NUM_SLICES-1:0] first_wr;
  logic [NUM_SLICES-1:0] sel;
  logic                  accept, last_grp, last_slice, last_line;

  always_comb begin
    gsum       = {1'b0, slice_width} + (W_W+1)'(PIX_PER_GROUP - 1);
    gpl        = (slice_width == '0) ? W_W'(1) : W_W'(gsum / (W_W+1)'(PIX_PER_GROUP));
    sel        = NUM_SLICES'(1) << cur_slice;
    in_ready   = (state == RUN) && !buf_almost_full[cur_slice];
    // frame_start wins over a same-cycle handshake, so that group is dropped
    accept     = in_valid && in_ready && !frame_start;
    last_grp   = (grp_cnt == gpl - W_W'(1));
    last_slice = (cur_slice == S_W'(NUM_SLICES - 1));
    last_line  = (line_cnt == slice_height - H_W'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (frame_start) state_nxt = RUN;
      RUN: begin
        if (frame_start) state_nxt = RUN;
        else if (accept && last_grp && last_slice && last_line) state_nxt = DONE;
      end
      DONE:    state_nxt = frame_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      wr_data    <= '0;
      wr_valid   <= '0;
      wr_sof     <= '0;
      cur_slice  <= '0;
      frame_done <= 1'b0;
      grp_cnt    <= '0;
      line_cnt   <= '0;
      first_wr   <= '1;
    end else begin
      wr_valid   <= '0;
      wr_sof     <= '0;
      frame_done <= (state == DONE) && !frame_start;
      if (frame_start) begin
        cur_slice <= '0;
        grp_cnt   <= '0;
        line_cnt  <= '0;
        first_wr  <= '1;
      end else if (accept) begin
        wr_data  <= in_data;
        wr_valid <= sel;
        wr_sof   <= sel & first_wr;
        first_wr <= first_wr & ~sel;
        if (last_grp) begin
          grp_cnt <= '0;
          if (last_slice) begin
            cur_slice <= '0;
            line_cnt  <= line_cnt + H_W'(1);
          end else begin
            cur_slice <= cur_slice + S_W'(1);
          end
        end else begin
          grp_cnt <= grp_cnt + W_W'(1);
        end
      end
    end
  end

`ifdef OUT_BUF_WR_SCHED_STATS_EN
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (frame_start)
      stall_cnt <= '0;
    else if ((state == RUN) && in_valid && !in_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_out_buf_wr_sched.sv
// Scoreboard bench for out_buf_wr_sched: a cycle model predicts accepts and queues expected writes.
module tb_out_buf_wr_sched;
  localparam int NS  = 4;
  localparam int DW  = 168;
  localparam int PPG = 4;
  localparam int WW  = 12;
  localparam int HW  = 12;
  localparam int SW  = 2;
`ifdef OUT_BUF_WR_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_wr = 1'b0;
  logic          rst_n = 1'b0;
  logic [WW-1:0] slice_width = '0;
  logic [HW-1:0] slice_height = '0;
  logic          frame_start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NS-1:0] buf_almost_full = '0;
  logic [DW-1:0] wr_data;
  logic [NS-1:0] wr_valid, wr_sof;
  logic [SW-1:0] cur_slice;
  logic          frame_done;
  logic [15:0]   stall_cnt;

  out_buf_wr_sched #(.NUM_SLICES(NS), .DATA_WIDTH(DW), .PIX_PER_GROUP(PPG),
                     .MAX_SLICE_WIDTH(2560), .MAX_SLICE_HEIGHT(2560)) dut (
    .clk_wr(clk_wr), .rst_n(rst_n), .slice_width(slice_width), .slice_height(slice_height),
    .frame_start(frame_start), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .buf_almost_full(buf_almost_full), .wr_data(wr_data), .wr_valid(wr_valid), .wr_sof(wr_sof),
    .cur_slice(cur_slice), .frame_done(frame_done), .stall_cnt(stall_cnt));

  always #5 clk_wr = ~clk_wr;

  typedef struct { int due; int slice; bit sof; logic [DW-1:0] data; } wr_t;
  typedef enum { M_IDLE, M_RUN, M_DONE } mstate_t;

  wr_t     exp_q[$];
  wr_t     mon_e;
  logic [NS-1:0] mon_v, mon_s;
  int      nchk = 0, nfail = 0, nwr = 0, ndone = 0, cyc = 0;
  int      exp_done_cyc = -1;
  bit      chk_en = 1'b0, exp_ready = 1'b0;
  mstate_t m_state = M_IDLE;
  int      m_slice = 0, m_grp = 0, m_line = 0, m_stall = 0, cfg_w = 0, cfg_h = 0;
  bit [NS-1:0] m_first = '1;

  always @(posedge clk_wr) cyc++;

  // Output monitor: every cycle compares handshake, write strobes and frame_done with the scoreboard
  always @(negedge clk_wr) if (chk_en) begin
    if (wr_valid !== '0) nwr++;
    if (frame_done === 1'b1) ndone++;
    nchk++;
    if (in_ready !== exp_ready) begin
      nfail++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      mon_v = NS'(1) << mon_e.slice;
      mon_s = mon_e.sof ? mon_v : '0;
      nchk++;
      if (wr_valid !== mon_v || wr_sof !== mon_s || wr_data !== mon_e.data) begin
        nfail++;
        $display("FAIL write cyc=%0d got v=%b sof=%b d=%h exp v=%b sof=%b d=%h",
                 cyc, wr_valid, wr_sof, wr_data, mon_v, mon_s, mon_e.data);
      end
    end else begin
      nchk++;
      if (wr_valid !== '0 || wr_sof !== '0) begin
        nfail++; $display("FAIL no_write cyc=%0d got v=%b sof=%b exp 0", cyc, wr_valid, wr_sof);
      end
    end
    nchk++;
    if (frame_done !== (cyc == exp_done_cyc)) begin
      nfail++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, cyc == exp_done_cyc);
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic set_cfg(input int w, input int h);
    cfg_w = w; cfg_h = h;
    slice_width = WW'(w); slice_height = HW'(h);
  endtask

  // Called at posedge+2: drives one cycle of inputs, predicts, then commits the model after the edge
  task automatic drive_cycle(input bit v, input logic [NS-1:0] af, input bit fs);
    logic [DW-1:0] d;
    mstate_t ns;
    int s, g, l, st, gpl;
    bit [NS-1:0] fw;
    bit acc;
    d = rand_data();
    in_valid = v; buf_almost_full = af; frame_start = fs; in_data = d;
    exp_ready = (m_state == M_RUN) && !af[m_slice];
    gpl = (cfg_w == 0) ? 1 : (cfg_w + PPG - 1) / PPG;
    acc = v && exp_ready && !fs;
    ns = m_state; s = m_slice; g = m_grp; l = m_line; st = m_stall; fw = m_first;
    if (fs) begin
      ns = M_RUN; s = 0; g = 0; l = 0; st = 0; fw = '1;
    end else begin
      if (m_state == M_DONE) begin ns = M_IDLE; exp_done_cyc = cyc + 1; end
      if (STATS && m_state == M_RUN && v && !exp_ready && st < 65535) st++;
      if (acc) begin
        exp_q.push_back('{due: cyc + 1, slice: m_slice, sof: m_first[m_slice], data: d});
        fw[m_slice] = 1'b0;
        if (m_grp == gpl - 1) begin
          g = 0;
          if (m_slice == NS - 1) begin
            s = 0; l = m_line + 1;
            if (m_line == cfg_h - 1) ns = M_DONE;
          end else s = m_slice + 1;
        end else g = m_grp + 1;
      end
    end
    @(posedge clk_wr); #2;
    m_state = ns; m_slice = s; m_grp = g; m_line = l; m_stall = st; m_first = fw;
  endtask

  task automatic run_until(input mstate_t target, input int budget);
    for (int i = 0; i < budget && m_state != target; i++) drive_cycle(1'b1, '0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_wr);
    #2;
    nchk++;
    if ({in_ready, wr_valid, wr_sof, cur_slice, frame_done, stall_cnt} !== '0 || wr_data !== '0) begin
      nfail++; $display("FAIL reset_vals rdy=%b v=%b sof=%b cs=%0d fd=%b st=%0d d=%h exp all 0",
                        in_ready, wr_valid, wr_sof, cur_slice, frame_done, stall_cnt, wr_data);
    end
    rst_n = 1'b1;
    exp_ready = 1'b0;
    chk_en = 1'b1;
    set_cfg(8, 2);
    repeat (3) drive_cycle(1'b1, '0, 1'b0);
    nchk++;
    if (nwr != 0) begin nfail++; $display("FAIL idle_ignore writes got=%0d exp=0", nwr); end
  endtask

  task automatic test_frame(input int w, input int h, input int exp_writes);
    int w0, d0;
    set_cfg(w, h);
    w0 = nwr; d0 = ndone;
    drive_cycle(1'b1, '0, 1'b1);
    run_until(M_IDLE, 200);
    repeat (2) drive_cycle(1'b0, '0, 1'b0);
    nchk++;
    if (nwr - w0 != exp_writes) begin
      nfail++; $display("FAIL frame_writes w=%0d got=%0d exp=%0d", w, nwr - w0, exp_writes);
    end
    nchk++;
    if (ndone - d0 != 1) begin nfail++; $display("FAIL frame_done_cnt w=%0d got=%0d exp=1", w, ndone - d0); end
    nchk++;
    if (cur_slice !== '0) begin nfail++; $display("FAIL end_slice got=%0d exp=0", cur_slice); end
  endtask

  task automatic test_backpressure();
    int w0, gpl_dummy;
    set_cfg(8, 2);
    drive_cycle(1'b0, '0, 1'b1);
    repeat (2) drive_cycle(1'b1, '0, 1'b0);
    nchk++;
    if (cur_slice !== SW'(1)) begin nfail++; $display("FAIL bp_target got=%0d exp=1", cur_slice); end
    drive_cycle(1'b1, 4'b0110, 1'b0);
    w0 = nwr;
    repeat (4) drive_cycle(1'b1, 4'b0110, 1'b0);
    nchk++;
    if (nwr != w0 || cur_slice !== SW'(1)) begin
      nfail++; $display("FAIL bp_hold writes=%0d cs=%0d exp writes=0 cs=1", nwr - w0, cur_slice);
    end
    repeat (2) drive_cycle(1'b1, 4'b0001, 1'b0);
    repeat (2) drive_cycle(1'b1, 4'b0100, 1'b0);
    gpl_dummy = 0;
    for (int i = 0; i < 40 && m_state == M_RUN && m_line == 0; i++)
      drive_cycle(1'($urandom_range(0, 1)), 4'b1000 & {NS{m_slice != 3}}, 1'b0);
    nchk++;
    if (stall_cnt !== 16'(STATS ? 7 : 0) || stall_cnt !== 16'(m_stall)) begin
      nfail++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, STATS ? 7 : 0);
    end
    run_until(M_IDLE, 100);
    drive_cycle(1'b0, '0, 1'b1);
    nchk++;
    if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL stall_clear got=%0d exp=0", stall_cnt); end
    run_until(M_IDLE, 100);
    drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_abort();
    int w0, d0;
    set_cfg(8, 2);
    w0 = nwr; d0 = ndone;
    drive_cycle(1'b0, '0, 1'b1);
    repeat (3) drive_cycle(1'b1, '0, 1'b0);
    drive_cycle(1'b1, '0, 1'b1);
    run_until(M_DONE, 100);
    drive_cycle(1'b1, '0, 1'b1);
    run_until(M_IDLE, 100);
    repeat (2) drive_cycle(1'b0, '0, 1'b0);
    nchk++;
    if (nwr - w0 != 3 + 16 + 16) begin nfail++; $display("FAIL abort_writes got=%0d exp=35", nwr - w0); end
    nchk++;
    if (ndone - d0 != 1) begin nfail++; $display("FAIL abort_done got=%0d exp=1", ndone - d0); end
  endtask

  task automatic test_reset_mid();
    set_cfg(8, 2);
    drive_cycle(1'b0, '0, 1'b1);
    repeat (3) drive_cycle(1'b1, '0, 1'b0);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({in_ready, wr_valid, wr_sof, cur_slice, frame_done, stall_cnt} !== '0 || wr_data !== '0) begin
      nfail++; $display("FAIL async_reset rdy=%b v=%b sof=%b cs=%0d fd=%b st=%0d exp all 0",
                        in_ready, wr_valid, wr_sof, cur_slice, frame_done, stall_cnt);
    end
    exp_q.delete();
    m_state = M_IDLE; m_slice = 0; m_grp = 0; m_line = 0; m_stall = 0; m_first = '1;
    exp_done_cyc = -1;
    @(posedge clk_wr); #2;
    rst_n = 1'b1;
    exp_ready = 1'b0;
    chk_en = 1'b1;
    repeat (3) drive_cycle(1'b1, '0, 1'b0);
    test_frame(8, 2, 16);
  endtask

  initial begin
    test_reset();
    test_frame(8, 2, 16);
    test_frame(10, 1, 12);
    test_frame(0, 1, 4);
    test_backpressure();
    test_abort();
    test_reset_mid();
    nchk++;
    if (exp_q.size() != 0) begin nfail++; $display("FAIL leftover_writes got=%0d exp=0", exp_q.size()); end
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/out_buf_wr_sched.md
Name: out_buf_wr_sched

Overview:
Write-side scheduler that distributes one decoded pixel-group stream across NUM_SLICES output synchronization buffers, one per slice, all on the clk_wr side.
- Sequences writes slice-by-slice, one slice line at a time, in round-robin order.
- Tags the first write of each slice per frame with SOF.
- Back-pressures the upstream decoder when the targeted buffer reports almost-full.
- Flags frame completion.

Parameters:
NUM_SLICES, 4, number of slices and buffers served
DATA_WIDTH, 168, pixel-group width (4 px x 3 comp x 14 b)
PIX_PER_GROUP, 4, pixels per write word
MAX_SLICE_WIDTH, 2560, maximum slice width in pixels
MAX_SLICE_HEIGHT, 2560, maximum slice height in lines

Ports:
clk_wr  in  1  write clock
rst_n  in  1  reset, asynchronous, active-low
slice_width  in  $clog2(MAX_SLICE_WIDTH)  slice width in pixels, stable per frame
slice_height  in  $clog2(MAX_SLICE_HEIGHT)  slice height in lines, stable per frame
frame_start  in  1  one-cycle pulse, begins/restarts a frame
in_data  in  DATA_WIDTH  pixel group from decoder
in_valid  in  1  in_data valid
in_ready  out  1  group accepted when in_valid & in_ready
buf_almost_full  in  NUM_SLICES  per-buffer almost-full, already in clk_wr domain
wr_data  out  DATA_WIDTH  data to all buffers
wr_valid  out  NUM_SLICES  one-hot write strobe
wr_sof  out  NUM_SLICES  SOF, coincident with that slice's first wr_valid of the frame
cur_slice  out  $clog2(NUM_SLICES)  slice currently targeted
frame_done  out  1  one-cycle pulse after last group of frame written
stall_cnt  out  16  stall statistics (see Optional Feature)

Behaviour:
- Reset values: in_ready=0, wr_valid=0, wr_sof=0, wr_data=0, cur_slice=0, frame_done=0, stall_cnt=0, FSM=IDLE, all counters 0, first_wr flags all 1.
- gpl (groups per line) = ceil(slice_width/PIX_PER_GROUP), computed combinationally. slice_width=0 is treated as gpl=1.
- FSM states:
  - IDLE: in_ready=0. frame_start -> RUN, with counters cleared and first_wr flags set.
  - RUN: in_ready = ~buf_almost_full[cur_slice].
    - On accept: grp_cnt increments.
    - When grp_cnt==gpl-1 on accept: grp_cnt->0 and cur_slice increments.
    - cur_slice wraps NUM_SLICES-1 -> 0, and line_cnt increments on the wrap.
    - Accept of the last group of slice NUM_SLICES-1 with line_cnt==slice_height-1 -> DONE.
  - DONE: one cycle; frame_done=1; -> IDLE. in_ready=0.
- Output timing:
  - wr_data and wr_valid are registered, 1 cycle after accept.
  - wr_valid[cur_slice at accept]=1, all other bits 0.
  - wr_sof[s]=1 on the same cycle when first_wr[s]=1; first_wr[s] is then cleared.
- Stall: buf_almost_full[cur_slice]=1 holds in_ready=0. No state change; upstream holds data. Almost-full of a non-targeted slice has no effect.
- frame_start during RUN or DONE aborts the frame:
  - next state RUN with counters and cur_slice zeroed, first_wr all set;
  - any accept in that same cycle is discarded (no wr_valid);
  - frame_done is not pulsed.
- frame_start has priority over every other event.
- in_valid in IDLE is ignored (in_ready=0).
- Reset mid-frame: immediate return to reset values; no partial writes emitted after reset deassertion.
- Counter widths: grp_cnt $clog2(MAX_SLICE_WIDTH), line_cnt $clog2(MAX_SLICE_HEIGHT); no overflow within legal ranges.

Optional Feature:
OUT_BUF_WR_SCHED_STATS_EN
- Defined: stall_cnt counts RUN cycles with in_valid=1 & in_ready=0. It saturates at 0xFFFF and clears on frame_start.
- Undefined: stall_cnt tied to 0, no counter logic.

Test Plan:
- NUM_SLICES=2, width=8, height=2, continuous in_valid, no almost-full:
  - 8 accepts; wr_valid sequence 01,01,10,10,01,01,10,10;
  - wr_sof 01 on write 1, 10 on write 3;
  - frame_done 1 cycle after write 8, then IDLE.
- width=10 (gpl=3), NUM_SLICES=4, height=1 -> 12 writes, 3 per slice in order 0,1,2,3; cur_slice ends at 0.
- buf_almost_full[1]=1 for 5 cycles while cur_slice=1:
  - in_ready=0 for those 5 cycles, no wr_valid;
  - resumes with slice 1 on the cycle after deassertion;
  - almost_full[2] asserted at the same time has no effect while slice 1 is targeted.
- frame_start after 3 of 8 groups:
  - no frame_done;
  - next write is to slice 0 with wr_sof=01;
  - the full 8-write sequence repeats.
- rst_n low mid-line -> all outputs 0 asynchronously; after release, in_ready=0 until frame_start.
- With OUT_BUF_WR_SCHED_STATS_EN defined: 7 stalled cycles with in_valid=1 -> stall_cnt=7; frame_start -> 0. Without the macro, stall_cnt stays 0.
